// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: round-robin sequencer sharing one I2C controller between NREQ clients.
// A client's request is latched into ctrl_*, the controller is started with a one-cycle
// ctrl_init, and its ctrl_done is returned to that client as a one-cycle rsp_done with an
// error flag accumulated over the whole transfer.
// Optional feature macro: I2C_ARB_TIMEOUT_EN enables a TO_CYCLES watchdog on the WAIT state.
module i2c_request_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TO_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [7*NREQ-1:0]    req_address,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [4*NREQ-1:0]    req_bytesend,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_done,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 ctrl_init,
  output logic                 ctrl_rw,
  output logic [6:0]           ctrl_address,
  output logic [31:0]          ctrl_data,
  output logic [3:0]           ctrl_bytesend,
  input  logic                 ctrl_done,
  input  logic                 ctrl_err
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e          state_q;
  logic [GW-1:0]   last_grant_q;
  logic            err_sticky_q;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0]   wd_cnt_q;
`endif

  logic            found_hi, found_lo;
  logic [GW-1:0]   hi_idx, lo_idx, gnt_idx;
  logic [NREQ-1:0] gnt_onehot, last_onehot;
  logic            gnt_rw;
  logic [6:0]      gnt_address;
  logic [31:0]     gnt_data;
  logic [3:0]      gnt_bytesend;

  // Round-robin pick: lowest valid index above last_grant, else lowest valid index (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_hi && req_valid[i] && (i > 32'(last_grant_q))) begin
        found_hi = 1'b1;
        hi_idx   = GW'(i);
      end
      if (!found_lo && req_valid[i]) begin
        found_lo = 1'b1;
        lo_idx   = GW'(i);
      end
    end
    gnt_idx = found_hi ? hi_idx : lo_idx;
  end

  // Select the winning client's fields and build the one-hot grant/response vectors.
  always_comb begin
    gnt_rw       = 1'b0;
    gnt_address  = '0;
    gnt_data     = '0;
    gnt_bytesend = '0;
    gnt_onehot   = '0;
    last_onehot  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == gnt_idx) begin
        gnt_onehot[i] = 1'b1;
        gnt_rw        = req_rw[i];
        gnt_address   = req_address[7*i +: 7];
        gnt_data      = req_data[32*i +: 32];
        gnt_bytesend  = req_bytesend[4*i +: 4];
      end
      if (GW'(i) == last_grant_q) begin
        last_onehot[i] = 1'b1;
      end
    end
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      last_grant_q  <= GW'(NREQ - 1);
      err_sticky_q  <= 1'b0;
      req_ack       <= '0;
      rsp_done      <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      ctrl_init     <= 1'b0;
      ctrl_rw       <= 1'b0;
      ctrl_address  <= '0;
      ctrl_data     <= '0;
      ctrl_bytesend <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (found_lo) begin
            ctrl_rw       <= gnt_rw;
            ctrl_address  <= gnt_address;
            ctrl_data     <= gnt_data;
            ctrl_bytesend <= gnt_bytesend;
            ctrl_init     <= 1'b1;
            req_ack       <= gnt_onehot;
            last_grant_q  <= gnt_idx;
            err_sticky_q  <= 1'b0;
            busy          <= 1'b1;
            state_q       <= StLaunch;
          end
        end
        StLaunch: begin
          // ctrl_done/ctrl_err in this cycle are deliberately ignored.
          ctrl_init <= 1'b0;
          req_ack   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt_q  <= '0;
`endif
          state_q   <= StWait;
        end
        StWait: begin
          err_sticky_q <= err_sticky_q | ctrl_err;
          if (ctrl_done) begin
            rsp_done <= last_onehot;
            rsp_err  <= err_sticky_q | ctrl_err;
            state_q  <= StResp;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd_cnt_q == CW'(TO_CYCLES - 1)) begin
            // Watchdog expiry completes the transfer with an error.
            rsp_done <= last_onehot;
            rsp_err  <= 1'b1;
            state_q  <= StResp;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          rsp_done <= '0;
          rsp_err  <= 1'b0;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
